// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between the EX stage (port 0, priority)
// and an auxiliary unit (port 1), with registered operands/results and starvation relief.
`default_nettype none

module alu_share_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [3:0]           op0,
  input  logic [3:0]           op1,
  input  logic [WORD_SIZE-1:0] a0,
  input  logic [WORD_SIZE-1:0] b0,
  input  logic [WORD_SIZE-1:0] a1,
  input  logic [WORD_SIZE-1:0] b1,
  input  logic                 cin0,
  input  logic                 cin1,
  output logic                 done0,
  output logic                 done1,
  output logic [WORD_SIZE-1:0] result,
  output logic                 cout,
  output logic [1:0]           cmp,
  output logic                 busy,
  output logic                 gnt_id,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  output logic                 alu_cin,
  output logic [3:0]           alu_op,
  input  logic [WORD_SIZE-1:0] alu_c,
  input  logic                 alu_cout,
  input  logic [1:0]           alu_cmp
);

  localparam logic [3:0] c_starve_limit = STARVE_LIMIT[3:0];

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_any_req;
  logic                   w_win1;
  logic                   w_grant;
  logic                   w_capture;

  logic [3:0]             r_starve;
  logic                   r_gnt;
  logic [3:0]             r_op;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_b;
  logic                   r_cin;
  logic [WORD_SIZE-1:0]   r_result;
  logic                   r_cout;
  logic [1:0]             r_cmp;
  logic                   r_done0;
  logic                   r_done1;

  assign w_any_req = req0 | req1;
  // Port 1 wins when alone, or when port 0 has beaten it STARVE_LIMIT times in a row.
  assign w_win1    = req1 & (~req0 | (r_starve == c_starve_limit));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_capture    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= 4'd0;
      r_gnt    <= 1'b0;
      r_op     <= 4'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_cin    <= 1'b0;
    end else if (w_grant) begin
      r_gnt <= w_win1;
      r_op  <= w_win1 ? op1  : op0;
      r_a   <= w_win1 ? a1   : a0;
      r_b   <= w_win1 ? b1   : b0;
      r_cin <= w_win1 ? cin1 : cin0;
      if (w_win1) begin
        r_starve <= 4'd0;
      end else if (req1 && (r_starve != c_starve_limit)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_cout   <= 1'b0;
      r_cmp    <= 2'b00;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
    end else begin
      r_done0 <= w_capture & ~r_gnt;
      r_done1 <= w_capture &  r_gnt;
      if (w_capture) begin
        r_result <= alu_c;
        r_cout   <= alu_cout;
        r_cmp    <= alu_cmp;
      end
    end
  end

  assign done0   = r_done0;
  assign done1   = r_done1;
  assign result  = r_result;
  assign cout    = r_cout;
  assign cmp     = r_cmp;
  assign busy    = (r_state == ST_EXEC);
  assign gnt_id  = r_gnt;
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_cin = r_cin;
  assign alu_op  = r_op;

endmodule

`default_nettype wire
